// File: rtl/adc_capture_wdog_pkg.sv
// Shared types and helpers for the adc_capture deadlock watchdog controller.
package adc_capture_wdog_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_SUSPECT = 3'd2,
    ST_TRIPPED = 3'd3,
    ST_RECOVER = 3'd4,
    ST_HOLDOFF = 3'd5
  } wdog_state_e;

  localparam int unsigned STATE_W      = 3;
  localparam int unsigned RPT_INFO_LSB = 0;

  // Trip count sits directly above the info field in rpt_data.
  function automatic int unsigned rpt_cnt_lsb(input int unsigned info_w);
    return info_w;
  endfunction

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Number of bits needed to hold the value v (at least 1).
  function automatic int unsigned bits_for(input int unsigned v);
    int unsigned w;
    w = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((v >> i) != 0) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/adc_capture_wdog_timer.sv
// Loadable saturating up-counter with terminal-count compare.
module adc_capture_wdog_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         inc_i,
  input  logic [W-1:0] term_val_i,
  output logic         term_o
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (inc_i && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign term_o = (count_q == term_val_i);

endmodule

// File: rtl/adc_capture_deadlock_watchdog_ctrl.sv
// Deadlock watchdog: debounces the HLS monitor block flag, latches stalled channels,
// raises irq plus a one-shot report, then sequences dataflow reset and re-arm holdoff.
module adc_capture_deadlock_watchdog_ctrl
  import adc_capture_wdog_pkg::*;
#(
  parameter int unsigned INFO_W          = 4,
  parameter int unsigned CNT_W           = 16,
  parameter int unsigned DEBOUNCE_CYCLES = 256,
  parameter int unsigned RESET_CYCLES    = 16,
  parameter int unsigned HOLDOFF_CYCLES  = 1024,
  parameter bit          AUTO_RECOVER    = 1'b1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    mon_block,
  input  logic [INFO_W-1:0]       mon_info,
  input  logic                    ack,
  input  logic                    clr_count,
  output logic                    df_reset,
  output logic                    irq,
  output logic [INFO_W-1:0]       tripped_info,
  output logic [CNT_W-1:0]        trip_count,
  output logic [STATE_W-1:0]      state,
  output logic                    rpt_valid,
  input  logic                    rpt_ready,
  output logic [CNT_W+INFO_W-1:0] rpt_data,
  output logic                    rpt_overrun
);

  localparam int unsigned TMR_W = bits_for(max3(DEBOUNCE_CYCLES, RESET_CYCLES, HOLDOFF_CYCLES));
  localparam logic [TMR_W-1:0] DEB_TERM = TMR_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TMR_W-1:0] RST_TERM = TMR_W'(RESET_CYCLES - 1);
  localparam logic [TMR_W-1:0] HO_TERM  = TMR_W'(HOLDOFF_CYCLES - 1);

  wdog_state_e             state_q, state_d;
  logic [INFO_W-1:0]       acc_q, acc_d;
  logic                    irq_q, irq_d;
  logic [INFO_W-1:0]       info_q, info_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d, cnt_inc;
  logic                    rvalid_q, rvalid_d;
  logic [CNT_W+INFO_W-1:0] rdata_q, rdata_d;
  logic                    ovr_q, ovr_d;
  logic                    dfr_q, dfr_d;

  logic                    trip_evt;
  logic [INFO_W-1:0]       trip_info;
  logic                    tmr_load, tmr_inc, tmr_term;
  logic [TMR_W-1:0]        tmr_load_val, tmr_term_val;

  // One timer serves SUSPECT, RECOVER and HOLDOFF; only the terminal value changes.
  adc_capture_wdog_timer #(
    .W (TMR_W)
  ) u_timer (
    .clock      (clock),
    .reset      (reset),
    .load_i     (tmr_load),
    .load_val_i (tmr_load_val),
    .inc_i      (tmr_inc),
    .term_val_i (tmr_term_val),
    .term_o     (tmr_term)
  );

  assign trip_info = acc_q | mon_info;

  always_ff @(posedge clock) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    trip_evt     = 1'b0;
    tmr_load     = 1'b0;
    tmr_load_val = '0;
    tmr_inc      = 1'b0;
    tmr_term_val = '0;
    case (state_q)
      ST_IDLE: begin
        if (enable) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end else if (mon_block) begin
          state_d      = ST_SUSPECT;
          acc_d        = mon_info;
          tmr_load     = 1'b1;
          tmr_load_val = TMR_W'(1);
        end
      end
      ST_SUSPECT: begin
        tmr_term_val = DEB_TERM;
        if (!enable) begin
          state_d = ST_IDLE;
          acc_d   = '0;
        end else if (!mon_block) begin
          state_d = ST_ARMED;
          acc_d   = '0;
        end else if (tmr_term) begin
          state_d  = ST_TRIPPED;
          trip_evt = 1'b1;
          acc_d    = '0;
        end else begin
          acc_d   = acc_q | mon_info;
          tmr_inc = 1'b1;
        end
      end
      ST_TRIPPED: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end else if (AUTO_RECOVER || ack) begin
          state_d  = ST_RECOVER;
          tmr_load = 1'b1;
        end
      end
      ST_RECOVER: begin
        // The pulse always runs to completion; enable only picks the exit state.
        tmr_term_val = RST_TERM;
        if (tmr_term) begin
          state_d  = enable ? ST_HOLDOFF : ST_IDLE;
          tmr_load = 1'b1;
        end else begin
          tmr_inc = 1'b1;
        end
      end
      ST_HOLDOFF: begin
        tmr_term_val = HO_TERM;
        if (!enable) begin
          state_d = ST_IDLE;
        end else if (tmr_term) begin
          state_d = ST_ARMED;
        end else begin
          tmr_inc = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    irq_d    = irq_q;
    info_d   = info_q;
    cnt_d    = cnt_q;
    ovr_d    = ovr_q;
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

    if (trip_evt)   irq_d = 1'b1;
    else if (ack)   irq_d = 1'b0;

    if (clr_count) begin
      cnt_d = '0;
      ovr_d = 1'b0;
    end

    if (rvalid_q && rpt_ready) rvalid_d = 1'b0;

    if (trip_evt) begin
      info_d = trip_info;
      cnt_d  = clr_count ? CNT_W'(1) : cnt_inc;
      // A still-pending report is preserved; the lost trip is flagged instead.
      if (!rvalid_q) begin
        rvalid_d                                 = 1'b1;
        rdata_d[RPT_INFO_LSB +: INFO_W]          = trip_info;
        rdata_d[rpt_cnt_lsb(INFO_W) +: CNT_W]    = cnt_d;
      end else begin
        ovr_d = 1'b1;
      end
    end

    dfr_d = (state_d == ST_RECOVER);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      acc_q    <= '0;
      irq_q    <= 1'b0;
      info_q   <= '0;
      cnt_q    <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      ovr_q    <= 1'b0;
      dfr_q    <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      irq_q    <= irq_d;
      info_q   <= info_d;
      cnt_q    <= cnt_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      ovr_q    <= ovr_d;
      dfr_q    <= dfr_d;
    end
  end

  assign df_reset     = dfr_q;
  assign irq          = irq_q;
  assign tripped_info = info_q;
  assign trip_count   = cnt_q;
  assign state        = state_q;
  assign rpt_valid    = rvalid_q;
  assign rpt_data     = rdata_q;
  assign rpt_overrun  = ovr_q;

endmodule

// File: tb/tb_adc_capture_deadlock_watchdog_ctrl.sv
// Bench for the deadlock watchdog: directed trips on an auto-recover and an ack-driven instance,
// reports checked by a queue-based monitor.
module tb_adc_capture_deadlock_watchdog_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic        en_a, mb_a, ack_a, clr_a, rdy_a;
  logic [3:0]  mi_a;
  logic        df_a, irq_a, rv_a, ovr_a;
  logic [3:0]  tinfo_a;
  logic [15:0] cnt_a;
  logic [2:0]  st_a;
  logic [19:0] rd_a;

  logic        en_b, mb_b, ack_b, clr_b, rdy_b;
  logic [3:0]  mi_b;
  logic        df_b, irq_b, rv_b, ovr_b;
  logic [3:0]  tinfo_b;
  logic [1:0]  cnt_b;
  logic [2:0]  st_b;
  logic [5:0]  rd_b;

  adc_capture_deadlock_watchdog_ctrl #(
    .INFO_W(4), .CNT_W(16), .DEBOUNCE_CYCLES(8), .RESET_CYCLES(16),
    .HOLDOFF_CYCLES(1024), .AUTO_RECOVER(1'b1)
  ) dut_a (
    .clock(clk), .reset(reset), .enable(en_a), .mon_block(mb_a), .mon_info(mi_a),
    .ack(ack_a), .clr_count(clr_a), .df_reset(df_a), .irq(irq_a),
    .tripped_info(tinfo_a), .trip_count(cnt_a), .state(st_a), .rpt_valid(rv_a),
    .rpt_ready(rdy_a), .rpt_data(rd_a), .rpt_overrun(ovr_a)
  );

  adc_capture_deadlock_watchdog_ctrl #(
    .INFO_W(4), .CNT_W(2), .DEBOUNCE_CYCLES(4), .RESET_CYCLES(4),
    .HOLDOFF_CYCLES(8), .AUTO_RECOVER(1'b0)
  ) dut_b (
    .clock(clk), .reset(reset), .enable(en_b), .mon_block(mb_b), .mon_info(mi_b),
    .ack(ack_b), .clr_count(clr_b), .df_reset(df_b), .irq(irq_b),
    .tripped_info(tinfo_b), .trip_count(cnt_b), .state(st_b), .rpt_valid(rv_b),
    .rpt_ready(rdy_b), .rpt_data(rd_b), .rpt_overrun(ovr_b)
  );

  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;
  bit          done   = 1'b0;
  logic [19:0] qa[$];
  logic [5:0]  qb[$];

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_a(input logic [2:0] s, input int maxc, input string nm);
    int k;
    k = 0;
    while (st_a !== s && k < maxc) begin
      cyc(1);
      k++;
    end
    chk(nm, 64'(st_a), 64'(s));
  endtask

  task automatic wait_b(input logic [2:0] s, input int maxc, input string nm);
    int k;
    k = 0;
    while (st_b !== s && k < maxc) begin
      cyc(1);
      k++;
    end
    chk(nm, 64'(st_b), 64'(s));
  endtask

  task automatic trip_b(input logic [3:0] info, input logic [1:0] exp_cnt, input string nm);
    mi_b = info;
    mb_b = 1'b1;
    qb.push_back({exp_cnt, info});
    cyc(4);
    mb_b = 1'b0;
    chk({nm, "_state"}, 64'(st_b), 64'(3));
    chk({nm, "_count"}, 64'(cnt_b), 64'(exp_cnt));
    ack_b = 1'b1;
    cyc(1);
    ack_b = 1'b0;
    wait_b(3'd1, 40, {nm, "_rearm"});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    en_a = 0; mb_a = 0; ack_a = 0; clr_a = 0; rdy_a = 1; mi_a = '0;
    en_b = 0; mb_b = 0; ack_b = 0; clr_b = 0; rdy_b = 1; mi_b = '0;
    fork
      begin : stim
        int bad;
        cyc(2);
        chk("rst_state",  64'(st_a),    64'(0));
        chk("rst_df",     64'(df_a),    64'(0));
        chk("rst_irq",    64'(irq_a),   64'(0));
        chk("rst_count",  64'(cnt_a),   64'(0));
        chk("rst_info",   64'(tinfo_a), 64'(0));
        chk("rst_valid",  64'(rv_a),    64'(0));
        chk("rst_ovr",    64'(ovr_a),   64'(0));
        chk("rst_b_state",64'(st_b),    64'(0));
        reset = 1'b0;
        en_a  = 1'b1;
        cyc(1);
        chk("arm", 64'(st_a), 64'(1));

        // 7 high samples: debounce not reached
        mi_a = 4'hF; mb_a = 1'b1;
        cyc(7);
        chk("t1_suspect", 64'(st_a), 64'(2));
        mb_a = 1'b0;
        cyc(1);
        chk("t1_back_armed", 64'(st_a),  64'(1));
        chk("t1_count",      64'(cnt_a), 64'(0));
        chk("t1_irq",        64'(irq_a), 64'(0));

        // 8 high samples: trip, recover, holdoff
        mi_a = 4'hD; mb_a = 1'b1;
        qa.push_back({16'd1, 4'hD});
        cyc(7);
        chk("t2_pre_trip", 64'(st_a), 64'(2));
        cyc(1);
        mb_a = 1'b0;
        chk("t2_tripped", 64'(st_a),    64'(3));
        chk("t2_irq",     64'(irq_a),   64'(1));
        chk("t2_info",    64'(tinfo_a), 64'hD);
        chk("t2_count",   64'(cnt_a),   64'(1));
        chk("t2_df_off",  64'(df_a),    64'(0));
        cyc(1);
        chk("t2_rec_first", 64'(df_a), 64'(1));
        chk("t2_rec_state", 64'(st_a), 64'(4));
        cyc(15);
        chk("t2_rec_last",  64'(df_a), 64'(1));
        cyc(1);
        chk("t2_rec_done",  64'(df_a), 64'(0));
        chk("t2_holdoff",   64'(st_a), 64'(5));
        cyc(1023);
        chk("t2_holdoff_end", 64'(st_a), 64'(5));
        cyc(1);
        chk("t2_rearmed", 64'(st_a), 64'(1));
        ack_a = 1'b1;
        cyc(1);
        ack_a = 1'b0;
        chk("ack_irq",   64'(irq_a),   64'(0));
        chk("ack_info",  64'(tinfo_a), 64'hD);
        clr_a = 1'b1;
        cyc(1);
        clr_a = 1'b0;
        chk("clr_count", 64'(cnt_a), 64'(0));

        // two trips with report never accepted
        rdy_a = 1'b0;
        mi_a = 4'h4; mb_a = 1'b1;
        qa.push_back({16'd1, 4'h5});
        cyc(3);
        mi_a = 4'h1;
        cyc(5);
        mb_a = 1'b0;
        chk("t3a_state", 64'(st_a),    64'(3));
        chk("t3a_info",  64'(tinfo_a), 64'h5);
        chk("t3a_valid", 64'(rv_a),    64'(1));
        wait_a(3'd1, 1100, "t3a_rearm");
        mi_a = 4'h2; mb_a = 1'b1;
        cyc(8);
        mb_a = 1'b0;
        chk("t3b_state", 64'(st_a),    64'(3));
        chk("t3b_info",  64'(tinfo_a), 64'h2);
        chk("t3b_count", 64'(cnt_a),   64'(2));
        chk("t3b_ovr",   64'(ovr_a),   64'(1));
        chk("t3b_data",  64'(rd_a),    64'({16'd1, 4'h5}));
        clr_a = 1'b1;
        cyc(1);
        clr_a = 1'b0;
        chk("t3_clr_count", 64'(cnt_a), 64'(0));
        chk("t3_clr_ovr",   64'(ovr_a), 64'(0));
        chk("t3_still_valid", 64'(rv_a), 64'(1));
        rdy_a = 1'b1;
        cyc(1);
        chk("t3_valid_drop", 64'(rv_a), 64'(0));
        wait_a(3'd1, 1100, "t3b_rearm");

        // enable dropped mid-pulse
        mi_a = 4'h8; mb_a = 1'b1;
        qa.push_back({16'd1, 4'h8});
        cyc(8);
        mb_a = 1'b0;
        chk("t5_tripped", 64'(st_a), 64'(3));
        cyc(3);
        chk("t5_rec3", 64'(df_a), 64'(1));
        en_a = 1'b0;
        cyc(13);
        chk("t5_rec16",       64'(df_a), 64'(1));
        chk("t5_rec16_state", 64'(st_a), 64'(4));
        cyc(1);
        chk("t5_df_end", 64'(df_a),    64'(0));
        chk("t5_idle",   64'(st_a),    64'(0));
        chk("t5_irq",    64'(irq_a),   64'(1));
        chk("t5_info",   64'(tinfo_a), 64'h8);
        chk("t5_count",  64'(cnt_a),   64'(1));

        // reset mid-pulse
        en_a = 1'b1;
        cyc(1);
        mi_a = 4'h3; mb_a = 1'b1;
        qa.push_back({16'd2, 4'h3});
        cyc(8);
        mb_a = 1'b0;
        cyc(3);
        chk("t5r_rec3", 64'(df_a), 64'(1));
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        en_a  = 1'b0;
        chk("t5r_df",    64'(df_a),  64'(0));
        chk("t5r_state", 64'(st_a),  64'(0));
        chk("t5r_count", 64'(cnt_a), 64'(0));
        chk("t5r_irq",   64'(irq_a), 64'(0));

        // ack-driven instance
        en_b = 1'b1;
        cyc(1);
        chk("b_arm", 64'(st_b), 64'(1));
        mi_b = 4'hA; mb_b = 1'b1;
        qb.push_back({2'd1, 4'hA});
        cyc(4);
        mb_b = 1'b0;
        chk("b_tripped", 64'(st_b),  64'(3));
        chk("b_irq",     64'(irq_b), 64'(1));
        bad = 0;
        for (int i = 0; i < 500; i++) begin
          cyc(1);
          if (df_b !== 1'b0 || st_b !== 3'd3) bad++;
        end
        chk("b_hold_tripped", 64'(bad), 64'(0));
        ack_b = 1'b1;
        cyc(1);
        ack_b = 1'b0;
        chk("b_ack_state", 64'(st_b),  64'(4));
        chk("b_ack_irq",   64'(irq_b), 64'(0));
        chk("b_ack_df",    64'(df_b),  64'(1));
        wait_b(3'd1, 40, "b_rearm");
        trip_b(4'h1, 2'd2, "b_trip2");
        trip_b(4'h2, 2'd3, "b_trip3");
        trip_b(4'h4, 2'd3, "b_trip4_sat");
        mi_b = 4'h6; mb_b = 1'b1;
        qb.push_back({2'd1, 4'h6});
        cyc(3);
        clr_b = 1'b1;
        cyc(1);
        clr_b = 1'b0;
        mb_b  = 1'b0;
        chk("b_clr_trip_state", 64'(st_b),  64'(3));
        chk("b_clr_trip_count", 64'(cnt_b), 64'(1));
        cyc(2);
        done = 1'b1;
      end
      begin : mon
        while (!done) begin
          @(negedge clk);
          if (rv_a === 1'b1 && rdy_a === 1'b1) begin
            if (qa.size() == 0) begin
              n_cmp++;
              n_fail++;
              $display("FAIL rpt_a: got unexpected %0h expected none", rd_a);
            end else begin
              chk("rpt_a", 64'(rd_a), 64'(qa.pop_front()));
            end
          end
          if (rv_b === 1'b1 && rdy_b === 1'b1) begin
            if (qb.size() == 0) begin
              n_cmp++;
              n_fail++;
              $display("FAIL rpt_b: got unexpected %0h expected none", rd_b);
            end else begin
              chk("rpt_b", 64'(rd_b), 64'(qb.pop_front()));
            end
          end
        end
      end
    join
    chk("rpt_a_pending", 64'(qa.size()), 64'(0));
    chk("rpt_b_pending", 64'(qb.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
